icache_miss_ctrl: RTL and testbench

- Miss-handling controller for the SM instruction cache: tracks outstanding line refills in a small MSHR table.
- Merges same-block misses from different warps and issues one memory read per block.
- On response, drives the tag/data array refill and a warp wake-up mask back to the warp scheduler.
- Sits between the icache lookup stage, the L2/memory request port and the icache arrays; set index and tag come from the same address split used by the icache.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_mshr_entry.sv | 41 ++++
 rtl/icache_miss_ctrl.sv | 103 ++++++++++
 tb/tb_icache_miss_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, MSHR entry states and address split for the icache miss path
package icache_pkg;
    localparam int XLEN             = 32;
    localparam int NUM_WARP         = 8;
    localparam int NUM_ENTRY        = 4;
    localparam int SETIDXBITS       = 5;
    localparam int BLOCK_OFFSETBITS = 3;
    localparam int WORD_OFFSETBITS  = 2;
    localparam int OFF_BITS         = BLOCK_OFFSETBITS + WORD_OFFSETBITS;
    localparam int BA_BITS          = XLEN - OFF_BITS;
    localparam int TAG_BITS         = BA_BITS - SETIDXBITS;
    localparam int LINE_WIDTH       = XLEN << BLOCK_OFFSETBITS;
    localparam int ID_BITS          = $clog2(NUM_ENTRY);
    localparam int WID_BITS         = $clog2(NUM_WARP);

    typedef enum logic [1:0] {INVALID, WAIT_ISSUE, WAIT_RSP} entry_state_e;

    // The block address is exactly {tag, setid}, so one struct serves all three views.
    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [SETIDXBITS-1:0] setid;
    } block_addr_t;

    function automatic block_addr_t split_addr(input logic [XLEN-1:0] a);
        return block_addr_t'(a[XLEN-1:OFF_BITS]);
    endfunction
endpackage

// File: rtl/icache_mshr_entry.sv
// icache_mshr_entry: one outstanding refill block with its warp wake-up mask
module icache_mshr_entry
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc,
    input  logic                merge,
    input  logic                issue,
    input  logic                rsp,
    input  logic [WID_BITS-1:0] wid,
    input  block_addr_t         lookup_ba,
    output entry_state_e        state,
    output block_addr_t         block_addr,
    output logic [NUM_WARP-1:0] mask,
    output logic                match
);
    logic [NUM_WARP-1:0] wid_bit;

    assign wid_bit = NUM_WARP'(1) << wid;
    assign match   = state != INVALID && block_addr == lookup_ba;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INVALID;
            block_addr <= '0;
            mask       <= '0;
        end else if (alloc) begin
            state      <= WAIT_ISSUE;
            block_addr <= lookup_ba;
            mask       <= wid_bit;
        end else begin
            if (merge) mask <= mask | wid_bit;
            if (issue) state <= WAIT_RSP;
            if (rsp) begin
                state <= INVALID;
                mask  <= '0;
            end
        end
    end
endmodule

// File: rtl/icache_miss_ctrl.sv
// icache_miss_ctrl: MSHR miss handler merging same-block misses into one refill read
module icache_miss_ctrl
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [XLEN-1:0]       miss_addr,
    input  logic [WID_BITS-1:0]   miss_wid,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [XLEN-1:0]       mem_req_addr,
    output logic [ID_BITS-1:0]    mem_req_id,
    input  logic                  mem_rsp_valid,
    input  logic [ID_BITS-1:0]    mem_rsp_id,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    output logic                  fill_valid,
    output logic [SETIDXBITS-1:0] fill_setid,
    output logic [TAG_BITS-1:0]   fill_tag,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic [NUM_WARP-1:0]   wakeup_mask,
    output logic                  busy
);
    block_addr_t          miss_ba;
    block_addr_t          ent_ba    [NUM_ENTRY];
    logic [NUM_WARP-1:0]  ent_mask  [NUM_ENTRY];
    entry_state_e         ent_state [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] hit, free, waiting, rsp_hit, issued, alloc, merge, cand;
    logic [ID_BITS-1:0]   alloc_id, issue_id;
    logic                 accept;

    assign miss_ba = split_addr(miss_addr);
    // A block being filled this cycle is refused; the warp's refetch will hit the new line.
    assign miss_ready = !(|(hit & rsp_hit)) && (|hit || |free);
    assign accept     = miss_valid && miss_ready;
    assign cand       = waiting & ~issued;

    always_comb begin
        alloc_id = '0;
        issue_id = '0;
        for (int j = NUM_ENTRY - 1; j >= 0; j--) begin
            alloc_id = free[j] ? ID_BITS'(j) : alloc_id;
            issue_id = cand[j] ? ID_BITS'(j) : issue_id;
        end
    end

    for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_ent
        assign free[i]    = ent_state[i] == INVALID;
        assign waiting[i] = ent_state[i] == WAIT_ISSUE;
        assign rsp_hit[i] = mem_rsp_valid && mem_rsp_id == ID_BITS'(i) && ent_state[i] == WAIT_RSP;
        assign issued[i]  = mem_req_valid && mem_req_ready && mem_req_id == ID_BITS'(i);
        assign merge[i]   = accept && hit[i];
        assign alloc[i]   = accept && !(|hit) && alloc_id == ID_BITS'(i);
        icache_mshr_entry u_ent (
            .clk        (clk),
            .rst        (rst),
            .alloc      (alloc[i]),
            .merge      (merge[i]),
            .issue      (issued[i]),
            .rsp        (rsp_hit[i]),
            .wid        (miss_wid),
            .lookup_ba  (miss_ba),
            .state      (ent_state[i]),
            .block_addr (ent_ba[i]),
            .mask       (ent_mask[i]),
            .match      (hit[i])
        );
    end

    // The presented request is frozen until accepted; only then is the next entry picked.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_id    <= '0;
        end else if (!mem_req_valid || mem_req_ready) begin
            mem_req_valid <= |cand;
            mem_req_id    <= issue_id;
            mem_req_addr  <= {ent_ba[issue_id], {OFF_BITS{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_valid  <= 1'b0;
            fill_setid  <= '0;
            fill_tag    <= '0;
            fill_data   <= '0;
            wakeup_mask <= '0;
            busy        <= 1'b0;
        end else begin
            fill_valid  <= |rsp_hit;
            wakeup_mask <= |rsp_hit ? ent_mask[mem_rsp_id] : '0;
            if (|rsp_hit) begin
                fill_setid <= ent_ba[mem_rsp_id].setid;
                fill_tag   <= ent_ba[mem_rsp_id].tag;
                fill_data  <= mem_rsp_data;
            end
            busy <= ~&free;
        end
    end
endmodule

// File: tb/tb_icache_miss_ctrl.sv
// tb_icache_miss_ctrl: directed vectors and sequences for the icache miss controller
module tb_icache_miss_ctrl;
    logic         clk = 0;
    logic         rst = 1;
    logic         miss_valid = 0;
    logic         miss_ready;
    logic [31:0]  miss_addr = 0;
    logic [2:0]   miss_wid = 0;
    logic         mem_req_valid;
    logic         mem_req_ready = 0;
    logic [31:0]  mem_req_addr;
    logic [1:0]   mem_req_id;
    logic         mem_rsp_valid = 0;
    logic [1:0]   mem_rsp_id = 0;
    logic [255:0] mem_rsp_data = 0;
    logic         fill_valid;
    logic [4:0]   fill_setid;
    logic [21:0]  fill_tag;
    logic [255:0] fill_data;
    logic [7:0]   wakeup_mask;
    logic         busy;

    int total = 0;
    int bad = 0;
    int nreq = 0;
    int n0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  wid;
        logic        exp_ready;
    } vec_t;
    vec_t tbl [8];

    icache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr), .miss_wid(miss_wid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id), .mem_rsp_data(mem_rsp_data),
        .fill_valid(fill_valid), .fill_setid(fill_setid), .fill_tag(fill_tag),
        .fill_data(fill_data), .wakeup_mask(wakeup_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req_valid && mem_req_ready) nreq <= nreq + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        miss_valid = 0;
        mem_rsp_valid = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic miss(input logic [31:0] a, input logic [2:0] w, input logic er, input string nm);
        miss_valid = 1;
        miss_addr = a;
        miss_wid = w;
        #1 chk({nm, " miss_ready"}, miss_ready, er);
        tick();
        miss_valid = 0;
    endtask

    task automatic wait_req(input logic [31:0] a, input logic [1:0] id, input string nm);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " req_valid"}, mem_req_valid, 1);
        chk({nm, " req_addr"}, mem_req_addr, a);
        chk({nm, " req_id"}, mem_req_id, id);
        tick();
    endtask

    task automatic chk_fill(input logic [255:0] d, input logic [4:0] sid, input logic [21:0] tg,
                            input logic [7:0] mk, input string nm);
        chk({nm, " fill_valid"}, fill_valid, 1);
        chk({nm, " fill_setid"}, fill_setid, sid);
        chk({nm, " fill_tag"}, fill_tag, tg);
        chk({nm, " wakeup_mask"}, wakeup_mask, mk);
        chk({nm, " fill_data"}, fill_data, d);
    endtask

    task automatic respond(input logic [1:0] id, input logic [255:0] d, input logic [4:0] sid,
                           input logic [21:0] tg, input logic [7:0] mk, input string nm);
        mem_rsp_valid = 1;
        mem_rsp_id = id;
        mem_rsp_data = d;
        tick();
        mem_rsp_valid = 0;
        chk_fill(d, sid, tg, mk, nm);
        tick();
        chk({nm, " fill one cycle"}, fill_valid, 0);
    endtask

    initial begin
        tbl[0] = '{32'h0000_3000, 3'd0, 1'b1};
        tbl[1] = '{32'h0000_3020, 3'd1, 1'b1};
        tbl[2] = '{32'h0000_3040, 3'd2, 1'b1};
        tbl[3] = '{32'h0000_3060, 3'd3, 1'b1};
        tbl[4] = '{32'h0000_3080, 3'd4, 1'b0};
        tbl[5] = '{32'h0000_3004, 3'd5, 1'b1};
        tbl[6] = '{32'h0000_307c, 3'd6, 1'b1};
        tbl[7] = '{32'h0000_3088, 3'd7, 1'b0};

        tick();
        tick();
        chk("reset req_valid", mem_req_valid, 0);
        chk("reset fill_valid", fill_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset wakeup_mask", wakeup_mask, 0);
        rst = 0;

        // single miss: block 0x82 -> setid 2, tag 4
        mem_req_ready = 1;
        miss(32'h0000_1040, 3'd2, 1, "single");
        wait_req(32'h0000_1040, 2'd0, "single");
        chk("single busy", busy, 1);
        respond(2'd0, {8{32'h1111_0000}}, 5'h02, 22'h4, 8'h04, "single");
        chk("single busy clear", busy, 0);

        // merge three warps into one block: one read, mask 0x2A
        mem_req_ready = 0;
        n0 = nreq;
        miss(32'h0000_2000, 3'd1, 1, "merge w1");
        miss(32'h0000_2000, 3'd3, 1, "merge w3");
        miss(32'h0000_2010, 3'd5, 1, "merge w5");
        mem_req_ready = 1;
        wait_req(32'h0000_2000, 2'd0, "merge");
        tick();
        tick();
        chk("merge request count", nreq - n0, 1);
        respond(2'd0, {8{32'h2222_0000}}, 5'h00, 22'h8, 8'h2A, "merge");

        // full table: fifth distinct block refused, merges still accepted
        mem_req_ready = 0;
        for (int k = 0; k < 8; k++) miss(tbl[k].addr, tbl[k].wid, tbl[k].exp_ready, $sformatf("full row%0d", k));
        chk("full req_valid", mem_req_valid, 1);
        chk("full req_id", mem_req_id, 0);
        chk("full req_addr", mem_req_addr, 32'h0000_3000);
        do_reset();

        // backpressure: request held stable, issue order 0,1,2, out-of-order responses
        miss(32'h0000_4000, 3'd0, 1, "bp a0");
        miss(32'h0000_4020, 3'd1, 1, "bp a1");
        miss(32'h0000_4040, 3'd2, 1, "bp a2");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp hold%0d valid", k), mem_req_valid, 1);
            chk($sformatf("bp hold%0d addr", k), mem_req_addr, 32'h0000_4000);
            chk($sformatf("bp hold%0d id", k), mem_req_id, 0);
            tick();
        end
        mem_req_ready = 1;
        wait_req(32'h0000_4000, 2'd0, "bp i0");
        wait_req(32'h0000_4020, 2'd1, "bp i1");
        wait_req(32'h0000_4040, 2'd2, "bp i2");
        mem_req_ready = 0;
        respond(2'd2, {8{32'h4444_0002}}, 5'h02, 22'h10, 8'h04, "bp r2");
        respond(2'd0, {8{32'h4444_0000}}, 5'h00, 22'h10, 8'h01, "bp r0");
        respond(2'd1, {8{32'h4444_0001}}, 5'h01, 22'h10, 8'h02, "bp r1");

        // collision and free-slot rule
        mem_req_ready = 1;
        miss(32'h0000_5000, 3'd0, 1, "col a0");
        wait_req(32'h0000_5000, 2'd0, "col a0");
        miss(32'h0000_5020, 3'd1, 1, "col a1");
        wait_req(32'h0000_5020, 2'd1, "col a1");
        miss(32'h0000_5040, 3'd2, 1, "col a2");
        wait_req(32'h0000_5040, 2'd2, "col a2");
        mem_req_ready = 0;
        mem_rsp_valid = 1;
        mem_rsp_id = 2'd1;
        mem_rsp_data = {8{32'h5555_0001}};
        miss(32'h0000_5020, 3'd3, 0, "col same block");
        mem_rsp_valid = 0;
        chk_fill({8{32'h5555_0001}}, 5'h01, 22'h14, 8'h02, "col r1");
        mem_rsp_valid = 1;
        mem_rsp_id = 2'd0;
        mem_rsp_data = {8{32'h5555_0000}};
        miss(32'h0000_5060, 3'd4, 1, "col new block");
        mem_rsp_valid = 0;
        chk_fill({8{32'h5555_0000}}, 5'h00, 22'h14, 8'h01, "col r0");
        mem_req_ready = 1;
        wait_req(32'h0000_5060, 2'd1, "col realloc");
        mem_req_ready = 0;
        respond(2'd1, {8{32'h5555_0003}}, 5'h03, 22'h14, 8'h10, "col r1b");
        respond(2'd2, {8{32'h5555_0002}}, 5'h02, 22'h14, 8'h04, "col r2");

        // reset with two refills outstanding
        mem_req_ready = 1;
        miss(32'h0000_6000, 3'd0, 1, "rst a0");
        wait_req(32'h0000_6000, 2'd0, "rst a0");
        miss(32'h0000_6020, 3'd1, 1, "rst a1");
        wait_req(32'h0000_6020, 2'd1, "rst a1");
        mem_req_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst busy", busy, 0);
        chk("rst req_valid", mem_req_valid, 0);
        mem_rsp_valid = 1;
        mem_rsp_id = 2'd0;
        tick();
        chk("rst late rsp0 fill", fill_valid, 0);
        mem_rsp_id = 2'd1;
        tick();
        mem_rsp_valid = 0;
        chk("rst late rsp1 fill", fill_valid, 0);
        tick();
        chk("rst late fill after", fill_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
